// File: rtl/div_unit_pkg.sv
// Shared definitions for the execute-stage divider: bus widths, handshake levels
// and the divider state encoding.
package div_unit_pkg;

   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 64;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Two's complement negation when cond is set, identity otherwise.
   function automatic logic [RegBus-1:0] negate_if(input logic [RegBus-1:0] value,
                                                   input logic              cond);
      return cond ? (~value + 1'b1) : value;
   endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle, result
// presented as {remainder, quotient} and held until the requester drops start.
module div_unit
   import div_unit_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    signed_div_i,
   input  logic [RegBus-1:0]       opdata1_i,
   input  logic [RegBus-1:0]       opdata2_i,
   input  logic                    start_i,
   input  logic                    annul_i,
   output logic [DoubleRegBus-1:0] result_o,
   output logic                    ready_o
);

   div_state_e        state;
   logic [4:0]        cnt;
   logic [RegBus-1:0] dividend;
   logic [RegBus-1:0] divisor;
   logic [RegBus-1:0] part_rem;
   logic              signed_op;
   logic              sign1;
   logic              sign2;

   logic [RegBus:0]   shifted;
   logic [RegBus:0]   trial;
   logic              trial_ok;
   logic [RegBus-1:0] rem_next;
   logic [RegBus-1:0] quot_next;
   logic [RegBus-1:0] quot_fixed;
   logic [RegBus-1:0] rem_fixed;

   // The partial remainder always stays below the divisor, so only 32 bits are
   // stored; the 33rd bit exists only in the shifted/trial values.
   always_comb begin
      shifted    = {part_rem, dividend[RegBus-1]};
      trial      = shifted - {1'b0, divisor};
      trial_ok   = ~trial[RegBus];
      rem_next   = trial_ok ? trial[RegBus-1:0] : shifted[RegBus-1:0];
      quot_next  = {dividend[RegBus-2:0], trial_ok};
      quot_fixed = negate_if(quot_next, signed_op & (sign1 ^ sign2));
      rem_fixed  = negate_if(rem_next, signed_op & sign1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= DivFree;
         cnt       <= '0;
         dividend  <= '0;
         divisor   <= '0;
         part_rem  <= '0;
         signed_op <= 1'b0;
         sign1     <= 1'b0;
         sign2     <= 1'b0;
         result_o  <= '0;
         ready_o   <= DivResultNotReady;
      end else begin
         case (state)
            DivFree: begin
               ready_o  <= DivResultNotReady;
               result_o <= '0;
               if (start_i == DivStart && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= DivByZero;
                  end else begin
                     state     <= DivOn;
                     cnt       <= '0;
                     part_rem  <= '0;
                     signed_op <= signed_div_i;
                     sign1     <= opdata1_i[RegBus-1];
                     sign2     <= opdata2_i[RegBus-1];
                     dividend  <= negate_if(opdata1_i, signed_div_i & opdata1_i[RegBus-1]);
                     divisor   <= negate_if(opdata2_i, signed_div_i & opdata2_i[RegBus-1]);
                  end
               end
            end
            DivByZero: begin
               state    <= DivEnd;
               result_o <= '0;
               ready_o  <= DivResultReady;
            end
            DivOn: begin
               if (annul_i) begin
                  state <= DivFree;
                  cnt   <= '0;
               end else begin
                  part_rem <= rem_next;
                  dividend <= quot_next;
                  if (cnt == 5'd31) begin
                     state    <= DivEnd;
                     cnt      <= '0;
                     result_o <= {rem_fixed, quot_fixed};
                     ready_o  <= DivResultReady;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
            end
            DivEnd: begin
               if (start_i == DivStop) begin
                  state    <= DivFree;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end
            end
            default: state <= DivFree;
         endcase
      end
   end

endmodule
